// File: rtl/id_pkg.sv
// Shared decode-stage definitions: opcode/funct constants, ID FSM states, bubble word.
package id_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [31:0] INST_NOP = '0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    KILL  = 2'd2
  } id_state_e;

endpackage

// File: rtl/id_fwd_mux.sv
// Operand forwarding mux: select 0 or any select above NFWD returns the
// register-file value, select k returns forwarding slice k-1.
module id_fwd_mux #(
  parameter  int XLEN = 32,
  parameter  int NFWD = 3,
  localparam int SELW = $clog2(NFWD + 1)
) (
  input  logic [XLEN-1:0]      rf,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  input  logic [SELW-1:0]      sel,
  output logic [XLEN-1:0]      q
);

  // Pick the forwarding slice matching sel, default to register-file data
  always_comb begin
    q = rf;
    for (int unsigned k = 1; k <= NFWD; k++) begin
      if (sel == SELW'(k)) q = fwd_data[(k-1)*XLEN +: XLEN];
    end
  end

endmodule

// File: rtl/id_stage_ctl_gen.sv
// Decode stage: IF/ID register with stall/flush, operand forwarding, branch
// and jump resolution, IF redirect and selectable squash / delay-slot policy.
// Optional build macro ID_PERF_CNT_EN adds saturating performance counters.
module id_stage_ctl_gen
  import id_pkg::*;
#(
  parameter  int XLEN      = 32,
  parameter  int NFWD      = 3,
  parameter  int BR_MODE   = 0,
  parameter  int WORD_ADDR = 0,
  localparam int SELW      = $clog2(NFWD + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          if_inst,
  input  logic [XLEN-1:0]      if_pc4,
  input  logic                 if_valid,
  input  logic                 ext_flush,
  input  logic                 ld_stall,
  input  logic [XLEN-1:0]      rf_a,
  input  logic [XLEN-1:0]      rf_b,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  input  logic [SELW-1:0]      fwd_sel_a,
  input  logic [SELW-1:0]      fwd_sel_b,
  output logic [31:0]          id_inst,
  output logic [XLEN-1:0]      id_pc4,
  output logic                 id_valid,
  output logic [XLEN-1:0]      id_a,
  output logic [XLEN-1:0]      id_b,
  output logic [XLEN-1:0]      id_imm,
  output logic                 redirect,
  output logic [XLEN-1:0]      redirect_pc,
  output logic                 if_hold
`ifdef ID_PERF_CNT_EN
  ,
  output logic [31:0]          perf_stall,
  output logic [31:0]          perf_kill,
  output logic [31:0]          perf_taken
`endif
);

  localparam int BR_SHIFT = (WORD_ADDR != 0) ? 0 : 2;
  localparam bit SQUASH   = (BR_MODE == 0);

  id_state_e       state;
  logic [5:0]      opcode;
  logic [5:0]      funct;
  logic            taken;
  logic            squash;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] j_target;

  assign opcode = id_inst[31:26];
  assign funct  = id_inst[5:0];

  id_fwd_mux #(.XLEN(XLEN), .NFWD(NFWD)) u_fwd_a (
    .rf(rf_a), .fwd_data(fwd_data), .sel(fwd_sel_a), .q(id_a)
  );

  id_fwd_mux #(.XLEN(XLEN), .NFWD(NFWD)) u_fwd_b (
    .rf(rf_b), .fwd_data(fwd_data), .sel(fwd_sel_b), .q(id_b)
  );

  // Immediate extension: logical immediates zero-extend, all others sign-extend
  always_comb begin
    if (opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI)
      id_imm = {{(XLEN-16){1'b0}}, id_inst[15:0]};
    else
      id_imm = {{(XLEN-16){id_inst[15]}}, id_inst[15:0]};
  end

  assign br_target = id_pc4 + (id_imm << BR_SHIFT);

  if (WORD_ADDR != 0) begin : g_jw
    assign j_target = {id_pc4[XLEN-1:26], id_inst[25:0]};
  end else begin : g_jb
    assign j_target = {id_pc4[XLEN-1:28], id_inst[25:0], 2'b00};
  end

  // Resolve branch/jump condition and select the matching target
  always_comb begin
    taken       = 1'b0;
    redirect_pc = br_target;
    case (opcode)
      OP_BEQ: taken = (id_a == id_b);
      OP_BNE: taken = (id_a != id_b);
      OP_J, OP_JAL: begin
        taken       = 1'b1;
        redirect_pc = j_target;
      end
      OP_RTYPE: begin
        if (funct == FN_JR) begin
          taken       = 1'b1;
          redirect_pc = id_a;
        end
      end
      default: ;
    endcase
  end

  // KILL always holds an invalid bubble, so the state term only reinforces id_valid
  assign redirect = taken & id_valid & (state != KILL) & ~ld_stall & ~ext_flush;
  assign if_hold  = ld_stall & ~ext_flush;
  assign squash   = redirect & SQUASH;

  // IF/ID register and control-hazard FSM, flush > stall > squash > load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_inst  <= INST_NOP;
      id_pc4   <= '1;
      id_valid <= 1'b0;
      state    <= RUN;
    end else if (ext_flush) begin
      id_inst  <= INST_NOP;
      id_valid <= 1'b0;
      state    <= RUN;
    end else if (ld_stall) begin
      state    <= STALL;
    end else if (squash) begin
      id_inst  <= INST_NOP;
      id_valid <= 1'b0;
      state    <= KILL;
    end else begin
      id_inst  <= if_inst;
      id_pc4   <= if_pc4;
      id_valid <= if_valid;
      state    <= RUN;
    end
  end

`ifdef ID_PERF_CNT_EN
  // Saturating event counters for stall cycles, squashes and taken transfers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall <= '0;
      perf_kill  <= '0;
      perf_taken <= '0;
    end else begin
      if (if_hold && perf_stall != '1)            perf_stall <= perf_stall + 32'd1;
      if (squash && !ext_flush && perf_kill != '1) perf_kill  <= perf_kill + 32'd1;
      if (redirect && perf_taken != '1)           perf_taken <= perf_taken + 32'd1;
    end
  end
`endif

endmodule
